// File: rtl/alarm_ctrl_if.sv
// Signal bundle between the comparator/button/seconds stages and the alarm controller.
// The master side drives the strobes and the match flag; the slave side drives the buzzer and lamps.
interface alarm_ctrl_if;
    logic       sec_tick;
    logic       equal;
    logic       stop;
    logic       snooze;
    logic       buzz;
    logic       ringing;
    logic       snoozing;
    logic [1:0] snooze_cnt;

    modport master (
        output sec_tick, equal, stop, snooze,
        input  buzz, ringing, snoozing, snooze_cnt
    );

    modport slave (
        input  sec_tick, equal, stop, snooze,
        output buzz, ringing, snoozing, snooze_cnt
    );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm sequencer: rings on a rising comparator match, handles snooze/stop and auto-timeout.
// All outputs are registered, so every output reacts one mclk cycle after its cause.
module alarm_ctrl #(
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned MAX_SNOOZE = 3
) (
    input  logic         mclk,
    input  logic         rst_n,
    alarm_ctrl_if.slave  bus
);
    localparam int unsigned RW = $clog2(RING_SEC);
    localparam int unsigned SW = $clog2(SNOOZE_SEC);
    localparam logic [RW-1:0] RING_LAST   = RW'(RING_SEC - 1);
    localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_SEC - 1);
    localparam logic [1:0]    SNZ_LIMIT   = 2'(MAX_SNOOZE);

    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

    state_t        state;
    logic          equal_q;
    logic [RW-1:0] ring_t;
    logic [SW-1:0] snz_t;
    logic          beep;
    logic          trig;

    assign trig = bus.equal & ~equal_q;

    // Priority inside each state: stop, then snooze, then the tick-driven step.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            equal_q        <= 1'b1;
            ring_t         <= '0;
            snz_t          <= '0;
            beep           <= 1'b0;
            bus.buzz       <= 1'b0;
            bus.ringing    <= 1'b0;
            bus.snoozing   <= 1'b0;
            bus.snooze_cnt <= '0;
        end else begin
            equal_q <= bus.equal;
            case (state)
                IDLE: begin
                    if (trig) begin
                        state          <= RING;
                        ring_t         <= '0;
                        beep           <= 1'b1;
                        bus.buzz       <= 1'b1;
                        bus.ringing    <= 1'b1;
                        bus.snooze_cnt <= '0;
                    end
                end
                RING: begin
                    if (bus.stop) begin
                        state       <= IDLE;
                        ring_t      <= '0;
                        beep        <= 1'b0;
                        bus.buzz    <= 1'b0;
                        bus.ringing <= 1'b0;
                    end else if (bus.snooze && (bus.snooze_cnt < SNZ_LIMIT)) begin
                        state          <= SNOOZE;
                        ring_t         <= '0;
                        snz_t          <= '0;
                        beep           <= 1'b0;
                        bus.buzz       <= 1'b0;
                        bus.ringing    <= 1'b0;
                        bus.snoozing   <= 1'b1;
                        bus.snooze_cnt <= bus.snooze_cnt + 2'd1;
                    end else if (bus.sec_tick) begin
                        if (ring_t == RING_LAST) begin
                            state       <= IDLE;
                            ring_t      <= '0;
                            beep        <= 1'b0;
                            bus.buzz    <= 1'b0;
                            bus.ringing <= 1'b0;
                        end else begin
                            ring_t   <= ring_t + 1'b1;
                            beep     <= ~beep;
                            bus.buzz <= ~beep;
                        end
                    end
                end
                SNOOZE: begin
                    if (bus.stop) begin
                        state          <= IDLE;
                        snz_t          <= '0;
                        bus.snoozing   <= 1'b0;
                        bus.snooze_cnt <= '0;
                    end else if (bus.sec_tick) begin
                        if (snz_t == SNOOZE_LAST) begin
                            state        <= RING;
                            snz_t        <= '0;
                            ring_t       <= '0;
                            beep         <= 1'b1;
                            bus.buzz     <= 1'b1;
                            bus.ringing  <= 1'b1;
                            bus.snoozing <= 1'b0;
                        end else begin
                            snz_t <= snz_t + 1'b1;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.buzz     <= 1'b0;
                    bus.ringing  <= 1'b0;
                    bus.snoozing <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Downstream of the time/timer comparator. Consumes its registered `equal` flag and runs the alarm: ring, snooze, stop and auto-timeout.
- Drives the buzzer enable and the status lamps.
- Clocked by the master clock `mclk`. Paced by the 1 Hz one-cycle `sec_tick` strobe from the seconds stage.

Parameters:
- RING_SEC, 60, seconds of ringing before automatic silence (>=2)
- SNOOZE_SEC, 300, seconds in snooze before re-ringing (>=2)
- MAX_SNOOZE, 3, snoozes allowed per alarm event (1..3)

Ports:
- mclk  input  1  master clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- sec_tick  input  1  one-cycle pulse once per second
- equal  input  1  comparator match flag; level, high for the whole matching minute
- stop  input  1  one-cycle debounced stop-button pulse
- snooze  input  1  one-cycle debounced snooze-button pulse
- buzz  output  1  buzzer drive; 1 Hz on/off pattern while ringing
- ringing  output  1  high in RING state
- snoozing  output  1  high in SNOOZE state
- snooze_cnt  output  2  snoozes used in the current alarm event

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; buzz, ringing, snoozing = 0; snooze_cnt = 0.
  - equal_q = 1, so a match already in progress at release does not fire.
  - Ring timer, snooze timer and beep phase = 0.
  - Reset mid-ring or mid-snooze aborts immediately.
- Edge detect:
  - equal_q <= equal every cycle.
  - trig = equal & ~equal_q.
  - One alarm event per match minute: after stop or timeout, `equal` still high does not retrigger.
- States: IDLE, RING, SNOOZE. All outputs are registered, one cycle of latency.
- IDLE:
  - trig -> RING with ring_t=0, beep=1, snooze_cnt=0.
  - ringing=1 and buzz=1 in the cycle after the trig edge.
  - stop and snooze are ignored.
- RING:
  - buzz = beep.
  - On each sec_tick: beep toggles and ring_t increments.
  - sec_tick with ring_t == RING_SEC-1 -> IDLE (timeout). buzz and ringing drop next cycle; snooze_cnt is held until the next trig.
  - stop -> IDLE.
  - snooze with snooze_cnt < MAX_SNOOZE -> SNOOZE: snz_t=0, snooze_cnt+1, buzz=0.
  - snooze with snooze_cnt == MAX_SNOOZE is ignored; ringing continues.
  - trig is ignored.
- SNOOZE:
  - buzz=0, snoozing=1.
  - On each sec_tick, snz_t increments.
  - sec_tick with snz_t == SNOOZE_SEC-1 -> RING with ring_t=0, beep=1.
  - stop -> IDLE and clears snooze_cnt.
  - snooze and trig are ignored.
- Simultaneous events, priority: stop > snooze > sec_tick-driven transition.
  - stop+snooze in RING -> IDLE.
  - snooze and timeout tick in the same cycle -> SNOOZE.
  - A tick that coincides with any transition does not also count in the new state.
- Widths:
  - ring_t is $clog2(RING_SEC) bits; snz_t is $clog2(SNOOZE_SEC) bits.
  - Counters never wrap: they are cleared on entry and exit at terminal value.
- sec_tick held high for multiple cycles is out of contract. The design counts each cycle; there is no internal edge detection.

Test Plan (bench uses RING_SEC=4, SNOOZE_SEC=3, MAX_SNOOZE=2, sec_tick every 10 cycles):
- Release rst_n with equal=1 held -> ringing stays 0; drop equal, raise it -> ringing=1 and buzz=1 one cycle after the rising edge.
- Ring untouched -> buzz pattern 1,0,1,0 across ticks; 4th tick -> ringing=0, buzz=0; equal still 1 -> no retrigger.
- Ring, then snooze -> snoozing=1, snooze_cnt=1, buzz=0; 3 ticks later ringing=1 and buzz=1. Snooze again -> snooze_cnt=2. Third snooze -> ignored, still ringing.
- Stop during RING and during SNOOZE -> IDLE next cycle; snooze_cnt=0 after the SNOOZE stop.
- stop and snooze in the same cycle while ringing -> IDLE. Snooze on the same cycle as the timeout tick -> SNOOZE, snooze_cnt=1.
- Assert rst_n low asynchronously mid-SNOOZE (between clock edges) -> all outputs 0 immediately; after release with equal=0, a fresh equal rising edge rings normally.
